wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline's MEM/WB writeback and results returned by long-latency units (multi-cycle mul/div, refilled loads). Long-latency results are buffered in a small FIFO. The pipeline normally has priority, and a starvation counter forces the buffered results through. The block sits between the MEM/WB pipeline register and the register file write port, and stalls MEM/WB when it takes the port away from the pipeline.

---
 rtl/wb_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the register-file write port between the MEM/WB writeback and the
//   results returned by long-latency units (mul/div, refilled loads).
//   Long-latency results wait in a small circular FIFO. The pipeline has
//   priority by default. A starvation counter forces the FIFO head through
//   after STARVE_MAX consecutive pipeline grants. While that happens, MEM/WB
//   is stalled.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   pipe_we/rd/data          MEM/WB writeback request (rd == 0 is ignored)
//   pipe_stall               hold MEM/WB this cycle (combinational)
//   ll_valid/rd/data         long-latency result handshake input
//   ll_ready                 FIFO has a free slot (from registered state only)
//   rf_we/waddr/wdata        registered register-file write port
//   fifo_count               current FIFO occupancy
module wb_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int REGW       = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_we,
    input  logic [REGW-1:0]          pipe_rd,
    input  logic [XLEN-1:0]          pipe_data,
    output logic                     pipe_stall,
    input  logic                     ll_valid,
    output logic                     ll_ready,
    input  logic [REGW-1:0]          ll_rd,
    input  logic [XLEN-1:0]          ll_data,
    output logic                     rf_we,
    output logic [REGW-1:0]          rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

    // FIFO storage
    logic [REGW-1:0] mem_rd_q   [DEPTH];
    logic [XLEN-1:0] mem_data_q [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic [SW-1:0]   starve_q, starve_d;

    logic            rf_we_q,    rf_we_d;
    logic [REGW-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    logic pipe_req;
    logic push;
    logic fifo_grant;
    logic pipe_grant;

    // Grant decision. ll_ready depends only on count_q, so a pop in this
    // cycle does not free a slot until the next cycle.
    always_comb begin
        pipe_req   = pipe_we && (pipe_rd != '0);
        ll_ready   = (count_q < DEPTH_C);
        // A handshake on x0 completes but the result is dropped.
        push       = ll_valid && ll_ready && (ll_rd != '0);
        fifo_grant = (count_q != '0) && (!pipe_req || (starve_q == STARVE_C));
        pipe_grant = pipe_req && !fifo_grant;
        pipe_stall = pipe_req && fifo_grant;
    end

    // Next-state logic
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        starve_d   = starve_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        // Pointers wrap naturally because DEPTH is a power of two.
        if (push)       wr_ptr_d = wr_ptr_q + PW'(1);
        if (fifo_grant) rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push, fifo_grant})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Count consecutive pipeline wins while something is waiting.
        if (fifo_grant || (count_q == '0)) begin
            starve_d = '0;
        end else if (pipe_grant && (starve_q != STARVE_C)) begin
            starve_d = starve_q + SW'(1);
        end

        if (fifo_grant) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = mem_rd_q[rd_ptr_q];
            rf_wdata_d = mem_data_q[rd_ptr_q];
        end else if (pipe_grant) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pipe_rd;
            rf_wdata_d = pipe_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // NOTE: FIFO storage has no reset; count/pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd_q[wr_ptr_q]   <= ll_rd;
            mem_data_q[wr_ptr_q] <= ll_data;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter (default parameters).
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_rd;
    logic [31:0] ll_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  fifo_count;

    wb_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .pipe_stall (pipe_stall),
        .ll_valid   (ll_valid),
        .ll_ready   (ll_ready),
        .ll_rd      (ll_rd),
        .ll_data    (ll_data),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus: inputs, expected combinational outputs before
    // the edge, and expected registered outputs after it.
    typedef struct {
        string       name;
        logic        pwe;
        logic [4:0]  prd;
        logic [31:0] pdata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic        e_stall;
        logic        e_ready;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [1:0]  e_cnt;
    } vec_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    vec_t vecs[$];
    wr_t  sb_q[$];

    function automatic vec_t row(input string name,
                                 input logic pwe, input logic [4:0] prd, input logic [31:0] pdata,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                                 input logic e_stall, input logic e_ready,
                                 input logic e_we, input logic [4:0] e_addr, input logic [31:0] e_data,
                                 input logic [1:0] e_cnt);
        vec_t v;
        v.name = name; v.pwe = pwe; v.prd = prd; v.pdata = pdata;
        v.lv = lv; v.lrd = lrd; v.ldata = ldata;
        v.e_stall = e_stall; v.e_ready = e_ready;
        v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        wr_t w;
        @(negedge clk);
        pipe_we   = v.pwe;
        pipe_rd   = v.prd;
        pipe_data = v.pdata;
        ll_valid  = v.lv;
        ll_rd     = v.lrd;
        ll_data   = v.ldata;
        #1;
        check({v.name, ".stall"}, 32'(pipe_stall), 32'(v.e_stall));
        check({v.name, ".ready"}, 32'(ll_ready), 32'(v.e_ready));
        if (v.e_we) begin
            w.addr = v.e_addr;
            w.data = v.e_data;
            sb_q.push_back(w);
        end
        @(posedge clk);
        #1;
        check({v.name, ".we"},    32'(rf_we),      32'(v.e_we));
        check({v.name, ".count"}, 32'(fifo_count), 32'(v.e_cnt));
        // Scoreboard: every port write must match the next expected write.
        if (rf_we) begin
            if (sb_q.size() == 0) begin
                check({v.name, ".sb_unexpected_write"}, 32'(1), 32'(0));
            end else begin
                w = sb_q.pop_front();
                check({v.name, ".waddr"}, 32'(rf_waddr), 32'(w.addr));
                check({v.name, ".wdata"}, rf_wdata, w.data);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        pipe_we   = 1'b0;
        pipe_rd   = '0;
        pipe_data = '0;
        ll_valid  = 1'b0;
        ll_rd     = '0;
        ll_data   = '0;

        //            name            pwe prd pdata          lv lrd ldata        stl rdy we addr data           cnt
        vecs.push_back(row("x0_write",     1, 0,  32'hAAAA0000, 0, 0,  32'h0,       0, 1, 0, 0,  32'h0,        0));
        vecs.push_back(row("pipe_only",    1, 5,  32'hDEADBEEF, 0, 0,  32'h0,       0, 1, 1, 5,  32'hDEADBEEF, 0));
        vecs.push_back(row("ll_accept",    0, 0,  32'h0,        1, 7,  32'h1234,    0, 1, 0, 0,  32'h0,        1));
        vecs.push_back(row("ll_drain",     0, 0,  32'h0,        0, 0,  32'h0,       0, 1, 1, 7,  32'h1234,     0));
        vecs.push_back(row("fill_0",       1, 1,  32'h100,      1, 10, 32'hA0,      0, 1, 1, 1,  32'h100,      1));
        vecs.push_back(row("fill_1",       1, 2,  32'h200,      1, 11, 32'hA1,      0, 1, 1, 2,  32'h200,      2));
        vecs.push_back(row("full_hold0",   1, 3,  32'h300,      1, 12, 32'hA2,      0, 0, 1, 3,  32'h300,      2));
        vecs.push_back(row("full_hold1",   1, 4,  32'h400,      1, 12, 32'hA2,      0, 0, 1, 4,  32'h400,      2));
        vecs.push_back(row("full_hold2",   1, 6,  32'h600,      1, 12, 32'hA2,      0, 0, 1, 6,  32'h600,      2));
        vecs.push_back(row("full_starve",  1, 8,  32'h800,      1, 12, 32'hA2,      1, 0, 1, 10, 32'hA0,       1));
        vecs.push_back(row("stall_replay", 1, 8,  32'h800,      1, 12, 32'hA2,      0, 1, 1, 8,  32'h800,      2));
        vecs.push_back(row("drain_a1",     0, 0,  32'h0,        0, 0,  32'h0,       0, 0, 1, 11, 32'hA1,       1));
        vecs.push_back(row("push_pop",     0, 0,  32'h0,        1, 13, 32'hA3,      0, 1, 1, 12, 32'hA2,       1));
        vecs.push_back(row("x0_ll_drop",   1, 9,  32'h900,      1, 0,  32'hDEAD,    0, 1, 1, 9,  32'h900,      1));
        vecs.push_back(row("drain_a3",     0, 0,  32'h0,        0, 0,  32'h0,       0, 1, 1, 13, 32'hA3,       0));
        vecs.push_back(row("starve_load",  1, 14, 32'h1400,     1, 15, 32'hB5,      0, 1, 1, 14, 32'h1400,     1));
        vecs.push_back(row("starve_p1",    1, 16, 32'h1600,     0, 0,  32'h0,       0, 1, 1, 16, 32'h1600,     1));
        vecs.push_back(row("starve_p2",    1, 17, 32'h1700,     0, 0,  32'h0,       0, 1, 1, 17, 32'h1700,     1));
        vecs.push_back(row("starve_p3",    1, 18, 32'h1800,     0, 0,  32'h0,       0, 1, 1, 18, 32'h1800,     1));
        vecs.push_back(row("starve_p4",    1, 19, 32'h1900,     0, 0,  32'h0,       0, 1, 1, 19, 32'h1900,     1));
        vecs.push_back(row("starve_fire",  1, 20, 32'h2000,     0, 0,  32'h0,       1, 1, 1, 15, 32'hB5,       0));
        vecs.push_back(row("starve_replay",1, 20, 32'h2000,     0, 0,  32'h0,       0, 1, 1, 20, 32'h2000,     0));
        vecs.push_back(row("idle",         0, 0,  32'h0,        0, 0,  32'h0,       0, 1, 0, 0,  32'h0,        0));

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst.we",    32'(rf_we),      32'(0));
        check("rst.waddr", 32'(rf_waddr),   32'(0));
        check("rst.wdata", rf_wdata,        32'h0);
        check("rst.count", 32'(fifo_count), 32'(0));
        check("rst.ready", 32'(ll_ready),   32'(1));
        check("rst.stall", 32'(pipe_stall), 32'(0));
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // With no grant the write port holds its last address and data.
        check("hold.waddr", 32'(rf_waddr), 32'(20));
        check("hold.wdata", rf_wdata,      32'h2000);

        // Mid-stream reset: load two FIFO entries, then reset between edges.
        apply(row("pre_rst_a", 1, 3, 32'h333, 1, 4, 32'h444, 0, 1, 1, 3, 32'h333, 1));
        apply(row("pre_rst_b", 1, 5, 32'h555, 1, 6, 32'h666, 0, 1, 1, 5, 32'h555, 2));
        @(negedge clk);
        pipe_we  = 1'b1;
        pipe_rd  = 5'd3;
        ll_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("midrst.we",    32'(rf_we),      32'(0));
        check("midrst.waddr", 32'(rf_waddr),   32'(0));
        check("midrst.wdata", rf_wdata,        32'h0);
        check("midrst.count", 32'(fifo_count), 32'(0));
        check("midrst.ready", 32'(ll_ready),   32'(1));
        check("midrst.stall", 32'(pipe_stall), 32'(0));
        pipe_we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        // Discarded entries must never reach the port.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("post_rst.we",    32'(rf_we),      32'(0));
            check("post_rst.count", 32'(fifo_count), 32'(0));
        end

        check("sb.drained", 32'(sb_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
